bus_arbiter_nm: RTL



---
 rtl/bus_arb_pkg.sv | 34 +++
 rtl/arb_rr_picker.sv | 35 +++
 rtl/bus_arbiter_nm.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared types and helpers for the N-master system-bus arbiter.
//   - arb_state_e : arbiter FSM state (IDLE / GRANT)
//   - owner_t     : split-owner register (valid flag + master index);
//                   OWNER_NONE means no master is parked at the split slave
//   - onehot_to_idx : one-hot (up to 8 bits) to binary index
package bus_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int OWNER_IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                   valid;
    logic [OWNER_IDX_W-1:0] idx;
  } owner_t;

  localparam owner_t OWNER_NONE = '{valid: 1'b0, idx: '0};

  // Highest set bit wins; callers only pass one-hot or zero vectors.
  function automatic logic [OWNER_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [OWNER_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = OWNER_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// arb_rr_picker
//   Combinational winner selection.
//   Ports:
//     i_req     : request vector (already masked for parked masters)
//     i_ptr     : round-robin start position
//     i_rr_mode : 1 = first request at/after i_ptr (wrapping), 0 = lowest index
//     o_idx     : winning index (0 when no request)
//     o_valid   : at least one request present
module arb_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_rr_mode,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int unsigned w_pos;

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = i_rr_mode ? ((int'(i_ptr) + k) % N) : k;
      if (!o_valid && i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_nm.sv
// bus_arbiter_nm
//   N-master system-bus arbiter with round-robin / fixed-priority selection,
//   optional hold timeout and single-slot split-transaction parking.
//   Ports:
//     clk, rstn   : clock, synchronous active-low reset
//     breq        : per-master request, held high for the whole transaction
//     sready      : per-slave ready; all must be high to start a new grant
//                   (the split slave is excluded while a master is parked)
//     ssplit      : split slave reports an outstanding split
//     bgrant      : one-hot grant (zero when idle)
//     msel        : binary index of the granted master (0 when idle)
//     msplit      : per-master parked flag (at most one bit)
//     split_grant : one-cycle pulse when the parked master is resumed
//     bus_busy    : a grant is held
//
//   Handshake: a master raises breq and keeps it high; it owns the bus for
//   every cycle bgrant[i] is high. Lowering breq releases the bus at the next
//   edge. A release is always followed by at least one all-zero bgrant cycle.
module bus_arbiter_nm
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int SPLIT_IDX   = 2,
  parameter int RR_MODE     = 1,
  parameter int MAX_HOLD    = 0,
  parameter int MSEL_W      = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic [NUM_SLAVES-1:0]  sready,
  input  logic                   ssplit,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MSEL_W-1:0]      msel,
  output logic [NUM_MASTERS-1:0] msplit,
  output logic                   split_grant,
  output logic                   bus_busy
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e             r_state;
  logic [MSEL_W-1:0]      r_gnt;
  owner_t                 r_owner;
  logic [MSEL_W-1:0]      r_ptr;
  logic [HOLD_W-1:0]      r_hold;
  logic [NUM_MASTERS-1:0] r_bgrant;
  logic [MSEL_W-1:0]      r_msel;
  logic [NUM_MASTERS-1:0] r_msplit;
  logic                   r_split_grant;
  logic                   r_bus_busy;

  logic [NUM_MASTERS-1:0] w_cand;
  logic [NUM_SLAVES-1:0]  w_rdy_mask;
  logic                   w_rdy;
  logic [MSEL_W-1:0]      w_win_idx;
  logic                   w_win_vld;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [MSEL_W-1:0]      w_win_sel;
  logic [NUM_MASTERS-1:0] w_gnt_oh;
  logic [NUM_MASTERS-1:0] w_own_oh;
  logic [MSEL_W-1:0]      w_own_sel;
  logic [NUM_MASTERS-1:0] w_others;
  logic                   w_hold_hit;

  // Parked master is invisible to arbitration until resumed.
  assign w_cand = breq & ~r_msplit;

  // While a split is pending the split slave is busy by design, so its
  // ready must not block other traffic.
  always_comb begin
    w_rdy_mask = '0;
    if (r_owner.valid) w_rdy_mask[SPLIT_IDX] = 1'b1;
  end
  assign w_rdy = &(sready | w_rdy_mask);

  arb_rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (MSEL_W)
  ) u_picker (
    .i_req     (w_cand),
    .i_ptr     (r_ptr),
    .i_rr_mode (RR_MODE != 0),
    .o_idx     (w_win_idx),
    .o_valid   (w_win_vld)
  );

  assign w_win_oh  = NUM_MASTERS'(1) << w_win_idx;
  assign w_win_sel = MSEL_W'(onehot_to_idx(MAX_MASTERS'(w_win_oh)));
  assign w_gnt_oh  = NUM_MASTERS'(1) << r_gnt;
  assign w_own_oh  = NUM_MASTERS'(1) << r_owner.idx;
  assign w_own_sel = MSEL_W'(r_owner.idx);

  // Timeout only matters if someone else is actually waiting.
  assign w_others   = breq & ~r_msplit & ~w_gnt_oh;
  assign w_hold_hit = (MAX_HOLD > 0) && (r_hold >= HOLD_MAX) && (|w_others);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '0;
      r_owner       <= OWNER_NONE;
      r_ptr         <= '0;
      r_hold        <= '0;
      r_bgrant      <= '0;
      r_msel        <= '0;
      r_msplit      <= '0;
      r_split_grant <= 1'b0;
      r_bus_busy    <= 1'b0;
    end else begin
      r_split_grant <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_owner.valid && !ssplit) begin
            // Resume the parked master ahead of any new request.
            r_state       <= ST_GRANT;
            r_gnt         <= w_own_sel;
            r_bgrant      <= w_own_oh;
            r_msel        <= w_own_sel;
            r_bus_busy    <= 1'b1;
            r_split_grant <= 1'b1;
            r_msplit      <= r_msplit & ~w_own_oh;
            r_owner       <= OWNER_NONE;
            r_hold        <= HOLD_W'(1);
          end else if (w_win_vld && w_rdy) begin
            r_state    <= ST_GRANT;
            r_gnt      <= w_win_sel;
            r_bgrant   <= w_win_oh;
            r_msel     <= w_win_sel;
            r_bus_busy <= 1'b1;
            r_hold     <= HOLD_W'(1);
            if (RR_MODE != 0) begin
              r_ptr <= (int'(w_win_idx) == NUM_MASTERS - 1) ? '0 : w_win_idx + 1'b1;
            end
          end
        end
        ST_GRANT: begin
          if (ssplit && !r_owner.valid) begin
            // Split beats a simultaneous breq fall: the master is parked.
            r_msplit   <= r_msplit | w_gnt_oh;
            r_owner    <= '{valid: 1'b1, idx: OWNER_IDX_W'(r_gnt)};
            r_state    <= ST_IDLE;
            r_bgrant   <= '0;
            r_msel     <= '0;
            r_bus_busy <= 1'b0;
          end else if (!breq[r_gnt] || w_hold_hit) begin
            r_state    <= ST_IDLE;
            r_bgrant   <= '0;
            r_msel     <= '0;
            r_bus_busy <= 1'b0;
          end else if ((MAX_HOLD > 0) && (r_hold < HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bgrant      = r_bgrant;
  assign msel        = r_msel;
  assign msplit      = r_msplit;
  assign split_grant = r_split_grant;
  assign bus_busy    = r_bus_busy;

endmodule
